// File: rtl/apb_sram_pkg.sv
// Shared widths, FSM states and captured-request payload for the APB SRAM slave.
package apb_sram_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SRAM_SIZE  = 1024;
    localparam int unsigned STRB_WIDTH     = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic                      err;
        logic [STRB_WIDTH-1:0]     strb;
    } req_t;

endpackage

// File: rtl/apb_sram_mem.sv
// Single-port synchronous SRAM with a registered read port.
// Byte-lane write enables are present when APB_SRAM_PSTRB_EN is defined.
module apb_sram_mem
    import apb_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_SRAM_SIZE,
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef APB_SRAM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] be,
`endif
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array storage is deliberately not reset.
    always_ff @(posedge clk) begin : write_port
        if (we) begin
`ifdef APB_SRAM_PSTRB_EN
            for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
`else
            mem[idx] <= wdata;
`endif
        end
    end

    // Read register holds between reads; rclr forces the error-read zero.
    always_ff @(posedge clk or negedge rst_n) begin : read_port
        if (!rst_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/apb_sram_slave.sv
// APB slave fronting the on-chip SRAM: fixed wait states, pslverr on out-of-range addresses.
// Define APB_SRAM_PSTRB_EN to add the pstrb byte-strobe input.
module apb_sram_slave
    import apb_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SRAM_SIZE   = DEF_SRAM_SIZE,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SRAM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned IDX_W = (SRAM_SIZE > 1) ? $clog2(SRAM_SIZE) : 1;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    state_e           state_q, state_d;
    req_t             req_q, req_d, req_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pready_d, pslverr_d;
    logic             mem_we, mem_re, mem_rclr;

    // Snapshot of the bus request; range check uses the full unsigned paddr.
    always_comb begin : capture
        req_in       = '0;
        req_in.addr  = DEF_ADDR_WIDTH'(paddr);
        req_in.write = pwrite;
        req_in.wdata = DEF_DATA_WIDTH'(pwdata);
        req_in.err   = (64'(paddr) >= 64'(SRAM_SIZE));
`ifdef APB_SRAM_PSTRB_EN
        req_in.strb  = STRB_WIDTH'(pstrb);
`else
        req_in.strb  = '1;
`endif
    end

    // pready_d is raised one clock ahead so the registered pready lands on the last ACCESS cycle.
    always_comb begin : fsm
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = SETUP;
                    req_d   = req_in;
                end
            end
            SETUP: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (!penable) begin
                    req_d = req_in;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    if (WS == '0) begin
                        pready_d  = 1'b1;
                        pslverr_d = req_q.err;
                    end
                end
            end
            ACCESS: begin
                if (pready || !psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == WS) begin
                        pready_d  = 1'b1;
                        pslverr_d = req_q.err;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mem_re   = pready_d && !req_q.write && !req_q.err;
    assign mem_rclr = pready_d && !req_q.write && req_q.err;
    assign mem_we   = pready && req_q.write && !req_q.err && (|req_q.strb);

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
        end
    end

    apb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SRAM_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .rclr  (mem_rclr),
        .idx   (IDX_W'(req_q.addr)),
        .wdata (DATA_WIDTH'(req_q.wdata)),
`ifdef APB_SRAM_PSTRB_EN
        .be    ((DATA_WIDTH/8)'(req_q.strb)),
`endif
        .rdata (prdata)
    );

endmodule
